// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - eight-digit seven-segment scan controller
// Scans a 32-bit hex value across eight digits, with tear-free frame-aligned updates and anode timing matched to a registered cathode decoder.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  encoded,
  output logic [7:0]  anode,
  output logic        pending,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [3:0]    encoded_q, encoded_d;
  logic [7:0]    anode_s1_q, anode_s1_d;
  logic [7:0]    anode_q, anode_d;

  logic          tc;
  logic          frame_wrap;
  logic [7:0]    lead_zero;
  logic          blank;

  always_comb begin
    tc         = (pcnt_q == PCNT_LAST);
    frame_wrap = tc && (idx_q == 3'd7);
    pcnt_d     = tc ? '0 : pcnt_q + PCNT_ONE;
    idx_d      = tc ? idx_q + 3'd1 : idx_q;
  end

  // Shadow transfer happens before the load capture so a load on the
  // boundary edge is kept for the next frame rather than lost.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // lead_zero[k]: every nibble from digit 7 down to digit k is zero.
  always_comb begin
    lead_zero = '0;
    for (int k = 0; k < 8; k++) begin
      lead_zero[k] = ((disp_q >> (4 * k)) == 32'h0);
    end
    blank = !digit_en[idx_q] ||
            (lz_blank && (idx_q != 3'd0) && lead_zero[idx_q]);
  end

  always_comb begin
    encoded_d  = disp_q[{idx_q, 2'b00} +: 4];
    anode_s1_d = blank ? 8'hFF : ~(8'h01 << idx_q);
    anode_d    = anode_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= 3'd0;
      disp_q     <= 32'h0;
      shadow_q   <= 32'h0;
      pending_q  <= 1'b0;
      encoded_q  <= 4'h0;
      anode_s1_q <= 8'hFF;
      anode_q    <= 8'hFF;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      encoded_q  <= encoded_d;
      anode_s1_q <= anode_s1_d;
      anode_q    <= anode_d;
    end
  end

  assign encoded    = encoded_q;
  assign anode      = anode_q;
  assign pending    = pending_q;
  assign frame_tick = frame_wrap;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int RD    = 4;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'h0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_blank = 1'b0;
  logic [3:0]  encoded;
  logic [7:0]  anode;
  logic        pending;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .encoded    (encoded),
    .anode      (anode),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: position in the scan follows from the number of
  // clock edges since reset release.
  int          m_t = 0;
  logic [31:0] m_disp = 32'h0;
  logic [31:0] m_shadow = 32'h0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_enc = 4'h0;
  logic [7:0]  m_an1 = 8'hFF;
  logic [7:0]  m_an = 8'hFF;

  function automatic logic [7:0] exp_sel(input int k, input logic [31:0] d,
                                         input logic [7:0] en, input logic lz);
    if (!en[k]) return 8'hFF;
    if (lz && k != 0 && (d >> (4 * k)) == 32'h0) return 8'hFF;
    return 8'hFF ^ (8'h01 << k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_disp   <= 32'h0;
      m_shadow <= 32'h0;
      m_pend   <= 1'b0;
      m_enc    <= 4'h0;
      m_an1    <= 8'hFF;
      m_an     <= 8'hFF;
    end else begin
      m_enc <= 4'((m_disp >> (4 * ((m_t / RD) % 8))) & 32'hF);
      m_an1 <= exp_sel((m_t / RD) % 8, m_disp, digit_en, lz_blank);
      m_an  <= m_an1;
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp <= m_shadow;
        m_pend <= 1'b0;
      end
      if (load) begin
        m_shadow <= value;
        m_pend   <= 1'b1;
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_encoded", 32'(encoded), 32'(m_enc));
    chk("model_anode", 32'(anode), 32'(m_an));
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_frame_tick", 32'(frame_tick),
        32'(rst_n && ((m_t % FRAME) == FRAME - 1)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] lzv;
  int c;

  initial begin
    lzv = 32'h00000305;
    step(3);
    chk("reset_encoded", 32'(encoded), 32'h0);
    chk("reset_anode", 32'(anode), 32'hFF);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_frame_tick", 32'(frame_tick), 32'h0);

    // t counts edges since release; each step lands on a negedge
    rst_n = 1'b1; value = 32'h76543210; load = 1'b1;
    step(1); load = 1'b0;
    chk("load_pending", 32'(pending), 32'h1);
    c = 1;
    while (!frame_tick && c < 100) begin
      step(1); c++;
    end
    chk("first_frame_tick_cycle", 32'(c), 32'd31);
    step(1);
    chk("boundary_pending_clear", 32'(pending), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step(k == 0 ? 2 : 4);
      chk("scan_encoded", 32'(encoded), 32'(k));
      chk("scan_anode", 32'(anode), 32'(8'hFF ^ (8'h01 << k)));
    end

    step(8);
    value = 32'hAAAAAAAA; load = 1'b1;
    step(1); load = 1'b0;
    chk("tear_pending", 32'(pending), 32'h1);
    chk("tear_old_digit", 32'(encoded), 32'h1);
    step(24);
    chk("tear_frame_tick", 32'(frame_tick), 32'h1);
    step(1);
    chk("tear_pending_clear", 32'(pending), 32'h0);
    step(1);
    chk("tear_new_digit", 32'(encoded), 32'hA);

    step(3);
    value = 32'h11111111; load = 1'b1;
    step(1); value = 32'h22222222;
    step(1); load = 1'b0;
    chk("dbl_pending", 32'(pending), 32'h1);
    step(27);
    chk("dbl_encoded", 32'(encoded), 32'h2);
    chk("dbl_pending_clear", 32'(pending), 32'h0);

    step(1);
    lz_blank = 1'b1; value = lzv; load = 1'b1;
    step(1); load = 1'b0;
    step(29);
    for (int k = 0; k < 8; k++) begin
      step(k == 0 ? 2 : 4);
      chk("lz_encoded", 32'(encoded), 32'((lzv >> (4 * k)) & 32'hF));
      chk("lz_anode", 32'(anode), 32'(k > 2 ? 8'hFF : 8'hFF ^ (8'h01 << k)));
    end
    value = 32'h0; load = 1'b1;
    step(1); load = 1'b0;
    step(1);
    for (int k = 0; k < 8; k++) begin
      step(k == 0 ? 2 : 4);
      chk("lz_zero_encoded", 32'(encoded), 32'h0);
      chk("lz_zero_anode", 32'(anode), 32'(k == 0 ? 8'hFE : 8'hFF));
    end

    step(2);
    digit_en = 8'h0F; lz_blank = 1'b0; value = 32'hFFFFFFFF; load = 1'b1;
    step(1); load = 1'b0;
    step(31);
    for (int k = 0; k < 8; k++) begin
      step(k == 0 ? 2 : 4);
      chk("en_encoded", 32'(encoded), 32'hF);
      chk("en_anode", 32'(anode), 32'(k < 4 ? 8'hFF ^ (8'h01 << k) : 8'hFF));
    end

    step(2);
    value = 32'h12345678; load = 1'b1;
    step(1); load = 1'b0;
    chk("rst_pre_pending", 32'(pending), 32'h1);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_anode", 32'(anode), 32'hFF);
    chk("rst_async_encoded", 32'(encoded), 32'h0);
    chk("rst_async_pending", 32'(pending), 32'h0);
    step(2);
    rst_n = 1'b1; digit_en = 8'hFF;
    step(1);
    chk("rel_anode_hold", 32'(anode), 32'hFF);
    chk("rel_encoded", 32'(encoded), 32'h0);
    step(1);
    chk("rel_anode_digit0", 32'(anode), 32'hFE);
    step(29);
    chk("rel_frame_tick", 32'(frame_tick), 32'h1);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds a 32-bit display value, steps through the eight digits at a programmable refresh rate, and presents one 4-bit hex nibble per slot to the downstream registered hex-to-cathode decoder. It also drives the active-low anodes, delayed so they line up with the decoder's registered cathode output. Value updates are tear-free: a new value is applied only at a frame boundary.

## Interface
- REFRESH_DIV, 100000: clocks per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- value  in  32  new display value; nibble k drives digit k (digit 7 is most significant).
- load  in  1  one-cycle strobe that captures `value` into the shadow register.
- digit_en  in  8  per-digit enable; 0 forces that digit dark.
- lz_blank  in  1  1 = blank leading zeros.
- encoded  out  4  nibble for the downstream cathode decoder.
- anode  out  8  active-low one-hot digit select, aligned with the decoder's cathode.
- pending  out  1  shadow holds a value not yet displayed.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1. Terminal count (TC) occurs when pcnt == REFRESH_DIV-1; pcnt then returns to 0.
- On TC, digit index `idx` (3 bits) increments, wrapping 7→0.
- Frame boundary: TC with idx == 7. On that edge:
  - idx becomes 0.
  - frame_tick = 1 for exactly that cycle.
  - If pending, the display register `disp` ← shadow and pending ← 0 on the same edge.
- load = 1: shadow ← value and pending ← 1.
  - A load while already pending overwrites the shadow; the last load before the boundary wins.
  - A load coincident with the frame boundary is captured into the shadow. The old shadow transfers to disp. pending stays 1, and the new value is applied at the next frame boundary.
- Digit k is blanked if either condition holds:
  - digit_en[k] == 0, or
  - lz_blank == 1, k ≠ 0, and disp nibbles 7..k are all zero. Digit 0 is never blanked by lz_blank, so 0 shows as a single "0".
- encoded is registered: encoded ← disp[4·idx +: 4] every cycle. It is not gated by blanking; blanking acts on the anodes only.
- anode: a one-hot-low select for idx, or 8'hFF if digit idx is blanked, is registered through two stages.
- No other state. Scanning is free-running; there is no stall input.

## Timing
- Reset values (asynchronous assert; release takes effect on the next clk edge):
  - pcnt = 0, idx = 0, disp = 0, shadow = 0.
  - encoded = 4'h0, anode = 8'hFF, pending = 0, frame_tick = 0.
- Latency and alignment:
  - encoded lags idx by 1 cycle.
  - anode lags idx by 2 cycles. The downstream decoder adds one register, so its cathode and anode change on the same edge and there is no ghosting.
  - For 2 cycles after reset release, anode stays 8'hFF before the digit-0 select appears.
- Slot length is exactly REFRESH_DIV clocks. A frame is 8·REFRESH_DIV clocks.
- frame_tick period is 8·REFRESH_DIV clocks. The first frame_tick comes 8·REFRESH_DIV − 1 cycles after reset release.
- load → disp latency runs from 1 cycle up to one full frame. After disp updates, the new nibble appears on encoded 1 cycle later.
- digit_en and lz_blank are sampled combinationally each cycle for the current idx, and their effect reaches anode 2 cycles later.
- Reset mid-frame: all state returns to its reset value immediately. A pending shadow is discarded.

## Test plan
- Reset/scan, REFRESH_DIV=4, load 32'h76543210, then wait one frame → encoded cycles 0,1,…,7 with 4 clocks per slot. anode follows 8'hFE, 8'hFD, …, 8'h7F, two cycles behind idx. frame_tick pulses every 32 clocks.
- Tear-free update: load 32'hAAAAAAAA mid-frame → pending = 1 and the old digits continue. At the frame boundary pending drops to 0, and the next slot shows encoded = 4'hA.
- Double load: load 32'h11111111, then 32'h22222222 in the same frame → only 2s are displayed; pending clears at the boundary.
- Leading zeros, lz_blank=1, value 32'h00000305 → anode stays 8'hFF for digits 7..3. Digits 2..0 are selected, showing 3, 0, 5. value 0 shows only digit 0.
- digit_en = 8'h0F with value 32'hFFFFFFFF → anode stays 8'hFF in slots 4..7; encoded is still 4'hF in every slot.
- Reset asserted mid-scan with pending = 1 → anode = 8'hFF and encoded = 4'h0 asynchronously; pending = 0. After release, scanning restarts at digit 0 with disp = 0.
